// File: rtl/cic_decim_comb_chain.sv
`default_nettype none
// ============================================================================
// Module      : cic_decim_comb_chain
// Description : Back end of a CIC decimator. Keeps one of every R valid input
//               samples, then runs the decimated stream through CIC_N cascaded
//               comb stages (y = x - x[n-CIC_M]) at full DW width with modular
//               wrap-around. Pruning/truncation happen downstream.
//
// Build option: define CIC_VARIABLE_RATE_EN to make the decimation ratio
//               runtime-programmable through s_axis_rate_*. Without it the
//               ratio is fixed at CIC_R and the rate ports are ignored.
//
// Ports       :
//   clk                 in   rising-edge clock
//   reset_n             in   asynchronous active-low reset
//   s_axis_in_tdata     in   [DW]      signed sample from the integrator chain
//   s_axis_in_tvalid    in             one sample per high cycle
//   s_axis_rate_tdata   in   [RATE_DW] new ratio (variable-rate build only)
//   s_axis_rate_tvalid  in             rate load strobe (variable-rate build)
//   m_axis_out_tdata    out  [DW]      filtered, decimated sample
//   m_axis_out_tvalid   out            one-cycle strobe for m_axis_out_tdata
//
// Revision    : 1.0 - initial release
// ============================================================================
module cic_decim_comb_chain #(
    parameter int DW      = 18,
    parameter int CIC_R   = 10,
    parameter int CIC_N   = 7,
    parameter int CIC_M   = 1,
    parameter int RATE_DW = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DW-1:0]      s_axis_in_tdata,
    input  logic               s_axis_in_tvalid,
    input  logic [RATE_DW-1:0] s_axis_rate_tdata,
    input  logic               s_axis_rate_tvalid,
    output logic [DW-1:0]      m_axis_out_tdata,
    output logic               m_axis_out_tvalid
);

`ifdef CIC_VARIABLE_RATE_EN
    // Counter must cover any ratio the rate bus can program.
    localparam int C_CNT_W = RATE_DW;
`else
    // Fixed ratio: counter only needs to reach CIC_R-1 (keep at least 1 bit).
    localparam int C_CNT_W = (CIC_R > 1) ? $clog2(CIC_R) : 1;
`endif

    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_last;      // counter value at which a sample is kept
    logic               w_rate_load;
    logic [DW-1:0]      r_ds_data;
    logic               r_ds_valid;

    // ------------------------------------------------------------------------
    // Ratio source
    // ------------------------------------------------------------------------
`ifdef CIC_VARIABLE_RATE_EN
    logic [C_CNT_W-1:0] r_rate;
    logic [C_CNT_W-1:0] w_rate_new;

    // A programmed ratio of 0 would never match the counter; treat it as 1.
    assign w_rate_new  = (s_axis_rate_tdata == '0) ? C_CNT_W'(1) : s_axis_rate_tdata;
    assign w_last      = r_rate - C_CNT_W'(1);
    assign w_rate_load = s_axis_rate_tvalid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rate <= C_CNT_W'(CIC_R);
        end else if (s_axis_rate_tvalid) begin
            r_rate <= w_rate_new;
        end
    end
`else
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(CIC_R - 1);

    logic w_unused;

    assign w_last      = C_LAST;
    assign w_rate_load = 1'b0;
    assign w_unused    = ^{s_axis_rate_tdata, s_axis_rate_tvalid};
`endif

    // ------------------------------------------------------------------------
    // Downsampler: counts valid inputs only; keeps the one at count R-1.
    // A rate load takes priority over a coincident sample, which is dropped.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_ds_data  <= '0;
            r_ds_valid <= 1'b0;
        end else begin
            r_ds_valid <= 1'b0;
            if (w_rate_load) begin
                r_cnt <= '0;
            end else if (s_axis_in_tvalid) begin
                if (r_cnt == w_last) begin
                    r_cnt      <= '0;
                    r_ds_data  <= s_axis_in_tdata;
                    r_ds_valid <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + C_CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Comb chain. Element 0 is the downsampler output, element k+1 is the
    // output of comb stage k.
    // ------------------------------------------------------------------------
    logic [DW-1:0] w_stage_data  [CIC_N+1];
    logic          w_stage_valid [CIC_N+1];

    assign w_stage_data[0]  = r_ds_data;
    assign w_stage_valid[0] = r_ds_valid;

    generate
        for (genvar k = 0; k < CIC_N; k++) begin : g_comb
            logic [DW-1:0] r_dly [CIC_M];   // r_dly[CIC_M-1] is x[n-CIC_M]
            logic [DW-1:0] r_out;
            logic          r_vld;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int j = 0; j < CIC_M; j++) begin
                        r_dly[j] <= '0;
                    end
                    r_out <= '0;
                    r_vld <= 1'b0;
                end else begin
                    r_vld <= w_stage_valid[k];
                    if (w_stage_valid[k]) begin
                        // Unsigned DW-bit subtraction is the intended modulo
                        // 2^DW CIC arithmetic; overflow wraps by design.
                        r_out    <= w_stage_data[k] - r_dly[CIC_M-1];
                        r_dly[0] <= w_stage_data[k];
                        for (int j = 1; j < CIC_M; j++) begin
                            r_dly[j] <= r_dly[j-1];
                        end
                    end
                end
            end

            assign w_stage_data[k+1]  = r_out;
            assign w_stage_valid[k+1] = r_vld;
        end
    endgenerate

    assign m_axis_out_tdata  = w_stage_data[CIC_N];
    assign m_axis_out_tvalid = w_stage_valid[CIC_N];

endmodule
`default_nettype wire

// File: tb/tb_cic_decim_comb_chain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cic_decim_comb_chain
// Description : Self-checking bench for cic_decim_comb_chain. Five instances
//               with different DW/R/N/M share one clock and reset. A model
//               keeps the full history of decimated samples and recomputes
//               each output by repeated M-lag differencing modulo 2^DW; a
//               negedge process checks every instance every cycle. Literal
//               hand-computed values pin both model and DUT.
//               Rate-programming checks run when CIC_VARIABLE_RATE_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_decim_comb_chain;

    localparam int NI = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [17:0] din  [NI];
    logic        vin  [NI];
    logic [17:0] dout [NI];
    logic        vout [NI];
    logic [7:0]  dout3;
    logic [15:0] rate_dat;
    logic        rate_vld;

    longint xin [NI];
    int     cyc = 0;
    int     vectors = 0;
    int     miscompares = 0;
    int     k3;

    // model state
    longint dec     [NI][256];
    int     nd      [NI];
    int     mcnt    [NI];
    int     rate    [NI];
    int     exp_due [NI][64];
    longint exp_val [NI][64];
    int     eh      [NI];
    int     et      [NI];
    longint xlog    [NI][16];
    int     nx      [NI];
    longint obs     [NI][16];
    int     obs_cyc [NI][16];
    int     no      [NI];
    longint v3      [4] = '{100, -100, 127, -128};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // DUT instances
    // ------------------------------------------------------------------------
    cic_decim_comb_chain #(.DW(18), .CIC_R(4), .CIC_N(1), .CIC_M(1), .RATE_DW(16)) u0 (
        .clk(clk), .reset_n(reset_n),
        .s_axis_in_tdata(din[0]), .s_axis_in_tvalid(vin[0]),
        .s_axis_rate_tdata(16'd0), .s_axis_rate_tvalid(1'b0),
        .m_axis_out_tdata(dout[0]), .m_axis_out_tvalid(vout[0]));

    cic_decim_comb_chain #(.DW(18), .CIC_R(4), .CIC_N(2), .CIC_M(1), .RATE_DW(16)) u1 (
        .clk(clk), .reset_n(reset_n),
        .s_axis_in_tdata(din[1]), .s_axis_in_tvalid(vin[1]),
        .s_axis_rate_tdata(16'd0), .s_axis_rate_tvalid(1'b0),
        .m_axis_out_tdata(dout[1]), .m_axis_out_tvalid(vout[1]));

    cic_decim_comb_chain #(.DW(18), .CIC_R(2), .CIC_N(1), .CIC_M(2), .RATE_DW(16)) u2 (
        .clk(clk), .reset_n(reset_n),
        .s_axis_in_tdata(din[2]), .s_axis_in_tvalid(vin[2]),
        .s_axis_rate_tdata(16'd0), .s_axis_rate_tvalid(1'b0),
        .m_axis_out_tdata(dout[2]), .m_axis_out_tvalid(vout[2]));

    cic_decim_comb_chain #(.DW(8), .CIC_R(1), .CIC_N(1), .CIC_M(1), .RATE_DW(16)) u3 (
        .clk(clk), .reset_n(reset_n),
        .s_axis_in_tdata(din[3][7:0]), .s_axis_in_tvalid(vin[3]),
        .s_axis_rate_tdata(16'd0), .s_axis_rate_tvalid(1'b0),
        .m_axis_out_tdata(dout3), .m_axis_out_tvalid(vout[3]));

    cic_decim_comb_chain #(.DW(18), .CIC_R(10), .CIC_N(1), .CIC_M(1), .RATE_DW(16)) u4 (
        .clk(clk), .reset_n(reset_n),
        .s_axis_in_tdata(din[4]), .s_axis_in_tvalid(vin[4]),
        .s_axis_rate_tdata(rate_dat), .s_axis_rate_tvalid(rate_vld),
        .m_axis_out_tdata(dout[4]), .m_axis_out_tvalid(vout[4]));

    assign dout[3] = {{10{dout3[7]}}, dout3};

    // ------------------------------------------------------------------------
    // Per-instance configuration
    // ------------------------------------------------------------------------
    function automatic int p_r(input int i);
        case (i)
            0, 1:    return 4;
            2:       return 2;
            3:       return 1;
            default: return 10;
        endcase
    endfunction

    function automatic int p_n(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int p_m(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic int p_dw(input int i);
        return (i == 3) ? 8 : 18;
    endfunction

    // ------------------------------------------------------------------------
    // Model
    // ------------------------------------------------------------------------
    function automatic longint wrap(input longint v, input int dw);
        longint m;
        longint r;
        m = longint'(1) << dw;
        r = v & (m - 1);
        if (r >= (m >>> 1)) r = r - m;
        return r;
    endfunction

    // Newest output = last element of the decimated sequence after applying
    // the M-lag difference N times (history before the first sample is 0).
    function automatic longint comb_out(input int i);
        longint t [256];
        for (int n = 0; n < nd[i]; n++) t[n] = dec[i][n];
        for (int s = 0; s < p_n(i); s++)
            for (int n = nd[i] - 1; n >= p_m(i); n--)
                t[n] = t[n] - t[n - p_m(i)];
        return wrap(t[nd[i] - 1], p_dw(i));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            nd[i] = 0; mcnt[i] = 0; rate[i] = p_r(i);
            eh[i] = 0; et[i] = 0; nx[i] = 0; no[i] = 0;
        end
    endtask

    task automatic model_accept(input int i);
        longint y;
        if (i == 4 && rate_vld) begin
            rate[4] = (rate_dat == 16'd0) ? 1 : int'(rate_dat);
            mcnt[4] = 0;
            return;
        end
        if (!vin[i]) return;
        if (mcnt[i] == rate[i] - 1) begin
            mcnt[i] = 0;
            dec[i][nd[i]] = wrap(xin[i], p_dw(i));
            nd[i]++;
            y = comb_out(i);
            exp_due[i][et[i] % 64] = cyc + 1 + p_n(i);
            exp_val[i][et[i] % 64] = y;
            et[i]++;
            if (nx[i] < 16) xlog[i][nx[i]] = y;
            nx[i]++;
        end else begin
            mcnt[i]++;
        end
    endtask

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    task automatic chk(input string nm, input int i, input longint act, input longint want);
        vectors++;
        if (act != want) begin
            miscompares++;
            $display("FAIL %s u%0d: got %0d, expected %0d (cycle %0d)", nm, i, act, want, cyc);
        end
    endtask

    task automatic lit(input int i, input int idx, input longint want);
        chk("literal_model", i, (idx < nx[i] && idx < 16) ? xlog[i][idx] : longint'(-999999), want);
        chk("literal_dut",   i, (idx < no[i] && idx < 16) ? obs[i][idx]  : longint'(-999999), want);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            longint act;
            act = longint'($signed(dout[i]));
            if (!reset_n) begin
                chk("reset_valid", i, longint'(vout[i]), 0);
                chk("reset_data",  i, act, 0);
            end else begin
                if (vout[i]) begin
                    if (no[i] < 16) begin
                        obs[i][no[i]] = act;
                        obs_cyc[i][no[i]] = cyc;
                    end
                    no[i]++;
                end
                if (eh[i] != et[i] && exp_due[i][eh[i] % 64] == cyc) begin
                    chk("out_valid", i, longint'(vout[i]), 1);
                    chk("out_data",  i, act, exp_val[i][eh[i] % 64]);
                    eh[i]++;
                end else begin
                    chk("idle_valid", i, longint'(vout[i]), 0);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 ns after the rising edge)
    // ------------------------------------------------------------------------
    task automatic set_in(input int i, input longint x);
        xin[i] = x;
        din[i] = x[17:0];
        vin[i] = 1'b1;
    endtask

    task automatic tick();
        for (int i = 0; i < NI; i++) model_accept(i);
        @(posedge clk);
        #2;
        for (int i = 0; i < NI; i++) vin[i] = 1'b0;
        rate_vld = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            din[i] = '0; vin[i] = 1'b0; xin[i] = 0;
        end
        rate_dat = '0;
        rate_vld = 1'b0;
        reset_n  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Ramp (u0), constant 1 (u1), wrap-around back-to-back (u3), 3t ramp (u4)
        for (int t = 0; t < 20; t++) begin
            if (t < 16) begin
                set_in(0, t);
                set_in(1, 1);
            end
            if (t == 3) k3 = cyc;
            if (t < 4) set_in(3, v3[t]);
            set_in(4, 3 * t);
            tick();
        end
        drain(6);
        lit(0, 0, 3); lit(0, 1, 4); lit(0, 2, 4); lit(0, 3, 4);
        chk("u0_first_latency", 0, obs_cyc[0][0], k3 + 2);
        lit(1, 0, 1); lit(1, 1, -1); lit(1, 2, 0); lit(1, 3, 0);
        lit(3, 0, 100); lit(3, 1, 56);
        lit(4, 0, 27); lit(4, 1, 30);

        // M=2 ramp, continuous
        for (int t = 0; t < 12; t++) begin
            set_in(2, t);
            tick();
        end
        drain(4);
        lit(2, 0, 1); lit(2, 1, 3); lit(2, 2, 4); lit(2, 3, 4); lit(2, 4, 4); lit(2, 5, 4);

        // Same ramp with valid every 3rd cycle, from a clean state
        do_reset();
        for (int t = 0; t < 36; t++) begin
            if (t % 3 == 0) set_in(2, t / 3);
            tick();
        end
        drain(4);
        lit(2, 0, 1); lit(2, 1, 3); lit(2, 2, 4); lit(2, 5, 4);
        chk("u2_gapped_spacing", 2, obs_cyc[2][1] - obs_cyc[2][0], 6);

        // Reset while a kept sample is in flight; next output sees zeroed delays
        do_reset();
        for (int t = 0; t < 4; t++) begin
            set_in(0, t);
            tick();
        end
        do_reset();
        for (int t = 0; t < 4; t++) begin
            set_in(0, 8 + t);
            tick();
        end
        drain(3);
        lit(0, 0, 11);
        chk("u0_outputs_after_reset", 0, no[0], 1);

`ifdef CIC_VARIABLE_RATE_EN
        // Rate 3 mid-stream, then rate 0 (acts as 1) colliding with a sample
        for (int t = 0; t < 5; t++) begin
            set_in(4, t);
            tick();
        end
        rate_dat = 16'd3; rate_vld = 1'b1;
        tick();
        for (int t = 0; t < 7; t++) begin
            set_in(4, 100 + t);
            tick();
        end
        rate_dat = 16'd0; rate_vld = 1'b1;
        set_in(4, 200);
        tick();
        for (int t = 1; t <= 3; t++) begin
            set_in(4, 10 * t);
            tick();
        end
        drain(4);
        lit(4, 0, 102); lit(4, 1, 3); lit(4, 2, -95); lit(4, 3, 10); lit(4, 4, 10);

        // Reset restores the ratio to CIC_R=10
        do_reset();
        for (int t = 1; t <= 10; t++) begin
            set_in(4, t);
            tick();
        end
        drain(4);
        lit(4, 0, 10);
        chk("u4_outputs_after_reset", 4, no[4], 1);
`endif

        for (int i = 0; i < NI; i++) chk("pending_expectations", i, et[i] - eh[i], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
